multi_sphere_scheduler: RTL and testbench

Per-pixel render sequencer for the ray tracer, and the parametrised successor to the single-sphere write/increment loop. It walks WriteX/WriteY over an H_RES x V_RES frame. For each pixel it waits for the ray LUT and tests the ray against N_SPHERES spheres through a req/valid handshake with the collision unit, keeping the closest hit. It then emits one frame-buffer write with that sphere's colour, or with the background colour if nothing was hit.

---
 rtl/render_pkg.sv | 26 ++
 rtl/closest_hit_tracker.sv | 45 ++++
 rtl/multi_sphere_scheduler.sv | 172 +++++++++++++++++
 tb/tb_multi_sphere_scheduler.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/render_pkg.sv
// Shared ray-tracer render types: 16.16 fixed-point distances, colours, vectors
// and the scheduler state encoding.
package render_pkg;

  typedef logic [31:0] fixed_real;
  typedef logic [23:0] color;

  typedef struct packed {
    fixed_real x;
    fixed_real y;
    fixed_real z;
  } vector;

  // Farthest distance a hit may have; anything at or beyond it counts as a miss.
  localparam fixed_real T_MAX_DEFAULT = 32'h0100_0000;

  typedef enum logic [2:0] {
    IDLE,
    RAY_WAIT,
    ISSUE,
    WAIT_RESP,
    WRITE,
    ADVANCE
  } sched_state_e;

endpackage

// File: rtl/closest_hit_tracker.sv
// Remembers the nearest sphere hit for the pixel being rendered.
// An update only lands when the new distance is strictly closer.
module closest_hit_tracker
  import render_pkg::*;
#(
  parameter int        IW    = 2,
  parameter fixed_real T_MAX = T_MAX_DEFAULT
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          update_i,
  input  fixed_real     tnew_i,
  input  logic [IW-1:0] idx_i,
  output fixed_real     tbest_o,
  output logic [IW-1:0] best_idx_o,
  output logic          hit_o
);

  fixed_real     tbest_q;
  logic [IW-1:0] best_idx_q;
  logic          hit_q;

  // Strict compare means an equal distance from a later sphere loses the tie.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tbest_q    <= T_MAX;
      best_idx_q <= '0;
      hit_q      <= 1'b0;
    end else if (clear_i) begin
      tbest_q    <= T_MAX;
      best_idx_q <= '0;
      hit_q      <= 1'b0;
    end else if (update_i && (tnew_i < tbest_q)) begin
      tbest_q    <= tnew_i;
      best_idx_q <= idx_i;
      hit_q      <= 1'b1;
    end
  end

  assign tbest_o    = tbest_q;
  assign best_idx_o = best_idx_q;
  assign hit_o      = hit_q;

endmodule

// File: rtl/multi_sphere_scheduler.sv
// Per-pixel render sequencer: rasters the frame, queries the collision unit once
// per sphere and writes the closest sphere's colour (or background) per pixel.
module multi_sphere_scheduler
  import render_pkg::*;
#(
  parameter int        H_RES     = 640,
  parameter int        V_RES     = 480,
  parameter int        N_SPHERES = 4,
  parameter int        RAY_LAT   = 2,
  parameter fixed_real T_MAX     = T_MAX_DEFAULT,
  parameter color      BG_COLOR  = 24'h000000,
  parameter int        XW        = 10,
  parameter int        YW        = 10,
  localparam int       IW        = (N_SPHERES > 1) ? $clog2(N_SPHERES) : 1
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [N_SPHERES*24-1:0] sph_col,
  output logic                   ct_req,
  output logic [IW-1:0]          ct_idx,
  output fixed_real              ct_tbest,
  input  logic                   ct_valid,
  input  logic                   ct_collide,
  input  fixed_real              ct_tnew,
  output logic [XW-1:0]          WriteX,
  output logic [YW-1:0]          WriteY,
  output logic                   fb_we,
  output color                   WriteColor,
  output logic                   busy,
  output logic                   frame_done
);

  localparam int            CW       = (RAY_LAT > 0) ? $clog2(RAY_LAT + 1) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_SPHERES - 1);
  localparam logic [XW-1:0] X_LAST   = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(V_RES - 1);

  sched_state_e  state_q;
  logic [CW-1:0] cnt_q;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic          req_q;
  logic [IW-1:0] idx_q;
  fixed_real     ct_tbest_q;
  logic          we_q;
  color          color_q;
  logic          busy_q;
  logic          done_q;

  fixed_real     tbest;
  logic [IW-1:0] best_idx;
  logic          hit;
  logic          trk_clear;
  logic          trk_update;
  color          best_col;

  assign trk_clear  = (state_q == RAY_WAIT) && (cnt_q == '0);
  assign trk_update = (state_q == WAIT_RESP) && ct_valid && ct_collide && !abort;
  assign best_col   = sph_col[24*int'(best_idx) +: 24];

  closest_hit_tracker #(
    .IW    (IW),
    .T_MAX (T_MAX)
  ) u_tracker (
    .clk_i      (Clk),
    .rst_ni     (Reset_n),
    .clear_i    (trk_clear),
    .update_i   (trk_update),
    .tnew_i     (ct_tnew),
    .idx_i      (idx_q),
    .tbest_o    (tbest),
    .best_idx_o (best_idx),
    .hit_o      (hit)
  );

  // fb_we and frame_done default low so each is a single-cycle pulse.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      req_q      <= 1'b0;
      idx_q      <= '0;
      ct_tbest_q <= '0;
      we_q       <= 1'b0;
      color_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      if (abort && (state_q != IDLE)) begin
        state_q <= IDLE;
        req_q   <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start && !abort) begin
              x_q     <= '0;
              y_q     <= '0;
              cnt_q   <= CW'(RAY_LAT);
              busy_q  <= 1'b1;
              state_q <= RAY_WAIT;
            end
          end
          RAY_WAIT: begin
            if (cnt_q == '0) begin
              idx_q   <= '0;
              state_q <= ISSUE;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          ISSUE: begin
            req_q      <= 1'b1;
            ct_tbest_q <= tbest;
            state_q    <= WAIT_RESP;
          end
          WAIT_RESP: begin
            if (ct_valid) begin
              req_q <= 1'b0;
              if (idx_q == LAST_IDX) begin
                state_q <= WRITE;
              end else begin
                idx_q   <= idx_q + 1'b1;
                state_q <= ISSUE;
              end
            end
          end
          WRITE: begin
            we_q    <= 1'b1;
            color_q <= hit ? best_col : BG_COLOR;
            state_q <= ADVANCE;
          end
          ADVANCE: begin
            state_q <= RAY_WAIT;
            cnt_q   <= CW'(RAY_LAT);
            if (x_q < X_LAST) begin
              x_q <= x_q + 1'b1;
            end else begin
              x_q <= '0;
              if (y_q < Y_LAST) begin
                y_q <= y_q + 1'b1;
              end else begin
                y_q     <= '0;
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= IDLE;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign ct_req     = req_q;
  assign ct_idx     = idx_q;
  assign ct_tbest   = ct_tbest_q;
  assign WriteX     = x_q;
  assign WriteY     = y_q;
  assign fb_we      = we_q;
  assign WriteColor = color_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_multi_sphere_scheduler.sv
// Bench for multi_sphere_scheduler on a 4x2 frame with 3 spheres, a randomized
// collision responder and a closest-hit reference model.
module tb_multi_sphere_scheduler;

  localparam int          H      = 4;
  localparam int          V      = 2;
  localparam int          N      = 3;
  localparam int          IW     = 2;
  localparam int          NPIX   = H * V;
  localparam logic [31:0] TMAX   = 32'h0100_0000;
  localparam logic [23:0] BG     = 24'h000000;
  localparam int          BUDGET = 3000;

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [N*24-1:0] sphCol = '0;
  logic          ct_req;
  logic [IW-1:0] ct_idx;
  logic [31:0]   ct_tbest;
  logic          ct_valid = 1'b0;
  logic          ct_collide = 1'b0;
  logic [31:0]   ct_tnew = '0;
  logic [9:0]    WriteX;
  logic [9:0]    WriteY;
  logic          fb_we;
  logic [23:0]   WriteColor;
  logic          busy;
  logic          frame_done;

  // stimulus-owned
  bit          hitTab[NPIX][N];
  logic [31:0] tTab[NPIX][N];
  logic [23:0] colTab[N];
  int          frameEpoch = 0;
  bit          interrupt = 1'b0;
  bit          strayEn = 1'b0;
  int          strayReq = 0;

  // responder-owned
  int          strayDone = 0;
  logic [31:0] seenTbest[NPIX][N];

  // compare-owned
  int          seenEpoch = 0;
  int          pixCount = 0;
  int          doneCount = 0;
  int          cycleNo = 0;
  int          lastWriteCycle = -10;
  logic [9:0]  capX[NPIX];
  logic [9:0]  capY[NPIX];
  logic [23:0] capColor[NPIX];

  int assertCount = 0;
  int failCount = 0;

  always #5 Clk = ~Clk;

  multi_sphere_scheduler #(
    .H_RES     (H),
    .V_RES     (V),
    .N_SPHERES (N),
    .RAY_LAT   (2),
    .T_MAX     (TMAX),
    .BG_COLOR  (BG),
    .XW        (10),
    .YW        (10)
  ) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .start      (start),
    .abort      (abort),
    .sph_col    (sphCol),
    .ct_req     (ct_req),
    .ct_idx     (ct_idx),
    .ct_tbest   (ct_tbest),
    .ct_valid   (ct_valid),
    .ct_collide (ct_collide),
    .ct_tnew    (ct_tnew),
    .WriteX     (WriteX),
    .WriteY     (WriteY),
    .fb_we      (fb_we),
    .WriteColor (WriteColor),
    .busy       (busy),
    .frame_done (frame_done)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Nearest hit strictly inside T_MAX; equal distances go to the lowest sphere.
  function automatic logic [23:0] modelColor(input int p);
    logic [31:0] minT = TMAX;
    for (int i = 0; i < N; i++)
      if (hitTab[p][i] && tTab[p][i] < minT) minT = tTab[p][i];
    if (minT == TMAX) return BG;
    for (int i = 0; i < N; i++)
      if (hitTab[p][i] && tTab[p][i] == minT) return colTab[i];
    return BG;
  endfunction

  function automatic logic [31:0] modelTbest(input int p, input int idx);
    logic [31:0] minT = TMAX;
    for (int j = 0; j < idx; j++)
      if (hitTab[p][j] && tTab[p][j] < minT) minT = tTab[p][j];
    return minT;
  endfunction

  function automatic logic [31:0] randT();
    if ($urandom_range(0, 4) == 0) return TMAX + 32'($urandom_range(0, 1));
    return 32'($urandom_range(1, 5)) << 16;
  endfunction

  // Collision unit: random 1..7 cycle latency, checks the request stays put.
  always begin : responder
    int p;
    int ii;
    int lat;
    bit broke;
    logic [IW-1:0] idxHeld;
    logic [31:0] tbHeld;
    @(negedge Clk);
    ct_valid = 1'b0;
    if (Reset_n && ct_req && !interrupt) begin
      p = (int'(WriteY) * H + int'(WriteX)) % NPIX;
      ii = (int'(ct_idx) < N) ? int'(ct_idx) : N - 1;
      idxHeld = ct_idx;
      tbHeld = ct_tbest;
      seenTbest[p][ii] = tbHeld;
      checkOutput("ctTbestAtReq", tbHeld, modelTbest(p, int'(idxHeld)));
      lat = $urandom_range(1, 7);
      broke = 1'b0;
      for (int k = 1; k < lat; k++) begin
        @(negedge Clk);
        if (interrupt) begin
          broke = 1'b1;
          break;
        end
        checkOutput("reqHeld", ct_req, 1);
        checkOutput("idxHeld", ct_idx, idxHeld);
        checkOutput("tbestHeld", ct_tbest, tbHeld);
      end
      if (!broke) begin
        ct_collide = hitTab[p][ii];
        ct_tnew = tTab[p][ii];
        ct_valid = 1'b1;
      end
    end else if (Reset_n && !ct_req &&
                 (strayReq != strayDone || (strayEn && $urandom_range(0, 4) == 0))) begin
      strayDone = strayReq;
      ct_collide = 1'b1;
      ct_tnew = '0;
      ct_valid = 1'b1;
    end
  end

  // Every write must be the next raster pixel carrying the model's colour.
  always @(negedge Clk) begin : compare
    int p;
    if (seenEpoch != frameEpoch) begin
      seenEpoch = frameEpoch;
      pixCount = 0;
    end
    if (fb_we) begin
      p = pixCount;
      if (p >= NPIX) begin
        checkOutput("extraWrite", 64'(p), 64'(NPIX - 1));
      end else begin
        checkOutput("writeX", WriteX, 64'(p % H));
        checkOutput("writeY", WriteY, 64'(p / H));
        checkOutput("writeColor", WriteColor, modelColor(p));
        capX[p] = WriteX;
        capY[p] = WriteY;
        capColor[p] = WriteColor;
        pixCount++;
      end
      lastWriteCycle = cycleNo;
    end
    if (frame_done) begin
      doneCount++;
      checkOutput("doneOneAfterWrite", 64'(cycleNo), 64'(lastWriteCycle + 1));
      checkOutput("doneWriteCount", 64'(pixCount), 64'(NPIX));
    end
    cycleNo++;
  end

  task automatic randomPixel(input int p);
    for (int i = 0; i < N; i++) begin
      hitTab[p][i] = 1'($urandom_range(0, 1));
      tTab[p][i] = randT();
    end
  endtask

  // mode 0: directed hit-ordering/tie/background pixels; mode 1: fully random.
  task automatic applyStimulus(input int mode);
    if (mode == 0) begin
      colTab[0] = 24'hFF0000;
      colTab[1] = 24'h00FF00;
      colTab[2] = 24'h0000FF;
      hitTab[0][0] = 1; tTab[0][0] = 32'h0003_0000;
      hitTab[0][1] = 1; tTab[0][1] = 32'h0001_0000;
      hitTab[0][2] = 0; tTab[0][2] = 32'h0000_8000;
      hitTab[1][0] = 1; tTab[1][0] = 32'h0002_0000;
      hitTab[1][1] = 0; tTab[1][1] = 32'h0000_1000;
      hitTab[1][2] = 1; tTab[1][2] = 32'h0002_0000;
      for (int i = 0; i < N; i++) begin
        hitTab[2][i] = 0;
        tTab[2][i] = 32'h0000_1000;
      end
      hitTab[3][0] = 0; tTab[3][0] = 32'h0000_1000;
      hitTab[3][1] = 1; tTab[3][1] = TMAX;
      hitTab[3][2] = 0; tTab[3][2] = 32'h0000_1000;
      for (int p = 4; p < NPIX; p++) randomPixel(p);
    end else begin
      for (int i = 0; i < N; i++) colTab[i] = 24'($urandom);
      for (int p = 0; p < NPIX; p++) randomPixel(p);
    end
    sphCol = {colTab[2], colTab[1], colTab[0]};
    frameEpoch++;
    @(negedge Clk);
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
  endtask

  task automatic waitFrameDone(input string name);
    int n = 0;
    while (!frame_done && n < BUDGET) begin
      @(negedge Clk);
      n++;
    end
    checkOutput({name, "Done"}, frame_done, 1);
    @(negedge Clk);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "WriteX"}, WriteX, 0);
    checkOutput({tag, "WriteY"}, WriteY, 0);
    checkOutput({tag, "ctReq"}, ct_req, 0);
    checkOutput({tag, "ctIdx"}, ct_idx, 0);
    checkOutput({tag, "ctTbest"}, ct_tbest, 0);
    checkOutput({tag, "fbWe"}, fb_we, 0);
    checkOutput({tag, "WriteColor"}, WriteColor, 0);
    checkOutput({tag, "busy"}, busy, 0);
    checkOutput({tag, "frameDone"}, frame_done, 0);
  endtask

  initial begin : stimulus
    int n;
    #3 Reset_n = 1'b0;
    #1 checkAllZero("reset");
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);

    start = 1'b1;
    abort = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    abort = 1'b0;
    checkOutput("abortWinsInIdle", busy, 0);

    // Frame A: hit ordering, tie and background pixels
    applyStimulus(0);
    checkOutput("busyAfterStart", busy, 1);
    waitFrameDone("frameA");
    checkOutput("hitOrderColor", capColor[0], 24'h00FF00);
    checkOutput("sphere2Tbest", seenTbest[0][2], 32'h0001_0000);
    checkOutput("tieColor", capColor[1], 24'hFF0000);
    checkOutput("noHitColor", capColor[2], 24'h000000);
    checkOutput("tmaxHitColor", capColor[3], 24'h000000);
    checkOutput("row1StartX", capX[4], 0);
    checkOutput("row1StartY", capY[4], 1);
    checkOutput("frameAWrites", 64'(pixCount), 64'(NPIX));
    checkOutput("frameADoneCount", 64'(doneCount), 1);
    checkOutput("idleX", WriteX, 0);
    checkOutput("idleY", WriteY, 0);
    checkOutput("idleBusy", busy, 0);

    // Frame B: random scene with stray ct_valid pulses outside WAIT_RESP
    strayEn = 1'b1;
    applyStimulus(1);
    waitFrameDone("frameB");
    checkOutput("frameBWrites", 64'(pixCount), 64'(NPIX));

    // Frame C: reset during WAIT_RESP of pixel (2,1)
    applyStimulus(1);
    n = 0;
    while (!(WriteX == 2 && WriteY == 1 && ct_req) && n < BUDGET) begin
      @(negedge Clk);
      n++;
    end
    checkOutput("reachPixel21", (WriteX == 2 && WriteY == 1 && ct_req), 1);
    interrupt = 1'b1;
    Reset_n = 1'b0;
    #1 checkAllZero("midReset");
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    repeat (3) @(negedge Clk);
    checkOutput("resetNoWrite", 64'(pixCount), 6);
    checkOutput("resetNoDone", 64'(doneCount), 2);
    checkOutput("resetIdleBusy", busy, 0);
    interrupt = 1'b0;

    // Frame D restarts from (0,0)
    applyStimulus(1);
    waitFrameDone("frameD");
    checkOutput("frameDFirstX", capX[0], 0);
    checkOutput("frameDWrites", 64'(pixCount), 64'(NPIX));

    // Frame E: abort during ISSUE of pixel (1,0), then a late ct_valid
    applyStimulus(1);
    n = 0;
    while (!(WriteX == 1 && WriteY == 0 && ct_req) && n < BUDGET) begin
      @(negedge Clk);
      n++;
    end
    checkOutput("reachPixel10", (WriteX == 1 && WriteY == 0 && ct_req), 1);
    n = 0;
    while (ct_req && n < BUDGET) begin
      @(negedge Clk);
      n++;
    end
    checkOutput("reachIssue", ct_req, 0);
    interrupt = 1'b1;
    abort = 1'b1;
    strayReq++;
    @(negedge Clk);
    abort = 1'b0;
    checkOutput("abortBusy", busy, 0);
    checkOutput("abortReq", ct_req, 0);
    checkOutput("abortWe", fb_we, 0);
    checkOutput("abortHoldX", WriteX, 1);
    checkOutput("abortHoldY", WriteY, 0);
    repeat (6) @(negedge Clk);
    checkOutput("lateValidIgnored", busy, 0);
    checkOutput("abortWrites", 64'(pixCount), 1);
    interrupt = 1'b0;

    // Frame F after abort writes (0,0) first
    applyStimulus(1);
    waitFrameDone("frameF");
    checkOutput("frameFFirstX", capX[0], 0);
    checkOutput("frameFFirstY", capY[0], 0);
    checkOutput("frameFWrites", 64'(pixCount), 64'(NPIX));
    checkOutput("totalDone", 64'(doneCount), 4);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
